core_run_ctrl: RTL

- Synthesizable run/reset sequencer for the single-cycle RISC-V core.
- Replaces the fixed "pulse reset, run N ns, finish" sequence with a parametrised controller that:
  - holds the core in reset for a programmable number of cycles,
  - runs it under a cycle budget,
  - detects program end (EBREAK or self-loop),
  - reports status and a cycle count.
- Sits between the board/bench top level and the core's reset input. It also observes the core's PC and fetched instruction.

---
 rtl/core_run_ctrl_if.sv | 79 +++++++
 rtl/core_run_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// core_run_ctrl_if
//   Bundles the control, observation and status signals between a run
//   sequencer (core_run_ctrl) and whoever drives it (board top or bench).
//
//   Optional feature macro: CORE_RUN_CTRL_PC_HIST_EN adds the HIST_DEPTH
//   parameter and the hist_idx / hist_pc signals.
//
//   Signals (direction seen from the slave / sequencer side):
//     start        in   single-cycle start pulse
//     abort        in   return to IDLE from RESET_HOLD or RUN
//     pc           in   core program counter, current cycle
//     instr        in   core fetched instruction, current cycle
//     core_rst     out  reset to the core
//     running      out  high while the core runs
//     done         out  high once the run has ended
//     halted       out  run ended by EBREAK or self-loop
//     timeout      out  run ended by budget exhaustion
//     cycle_count  out  RUN cycles elapsed (saturating)
//     halt_pc      out  pc captured at the end condition
//     dbg_state    out  FSM state: 0 IDLE, 1 RESET_HOLD, 2 RUN, 3 DONE
//     hist_idx     in   (optional) history entry, 0 = newest
//     hist_pc      out  (optional) pc stored at that history entry
//
//   Handshake: start and abort are sampled on every rising clk edge; the
//   sequencer never back-pressures, it simply ignores a start that arrives
//   outside IDLE/DONE and an abort that arrives outside RESET_HOLD/RUN.
// -----------------------------------------------------------------------------
interface core_run_ctrl_if #(
  parameter int W = 32
`ifdef CORE_RUN_CTRL_PC_HIST_EN
  , parameter int HIST_DEPTH = 4
`endif
);

  logic         start;
  logic         abort;
  logic [W-1:0] pc;
  logic [W-1:0] instr;
  logic         core_rst;
  logic         running;
  logic         done;
  logic         halted;
  logic         timeout;
  logic [W-1:0] cycle_count;
  logic [W-1:0] halt_pc;
  logic [1:0]   dbg_state;

`ifdef CORE_RUN_CTRL_PC_HIST_EN
  localparam int HW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  logic [HW-1:0] hist_idx;
  logic [W-1:0]  hist_pc;

  modport master (
    output start, abort, pc, instr, hist_idx,
    input  core_rst, running, done, halted, timeout, cycle_count, halt_pc,
           dbg_state, hist_pc
  );

  modport slave (
    input  start, abort, pc, instr, hist_idx,
    output core_rst, running, done, halted, timeout, cycle_count, halt_pc,
           dbg_state, hist_pc
  );
`else
  modport master (
    output start, abort, pc, instr,
    input  core_rst, running, done, halted, timeout, cycle_count, halt_pc,
           dbg_state
  );

  modport slave (
    input  start, abort, pc, instr,
    output core_rst, running, done, halted, timeout, cycle_count, halt_pc,
           dbg_state
  );
`endif

endinterface

// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
//   Run/reset sequencer for the single-cycle RISC-V core. Holds the core in
//   reset for RST_CYCLES cycles after a start, lets it run under a budget of
//   MAX_CYCLES cycles, detects program end (EBREAK or a PC that stays put for
//   STALL_LIMIT cycles) and reports status plus a cycle count. All outputs
//   are registered.
//
//   Optional feature macro: CORE_RUN_CTRL_PC_HIST_EN
//     Adds a HIST_DEPTH-entry circular buffer of PCs recorded on every RUN
//     cycle whose pc differs from the previous one; read via hist_idx/hist_pc.
//
//   Ports:
//     clk   in   system clock, rising edge
//     rst   in   synchronous active-high reset
//     bus   slave modport of core_run_ctrl_if (start/abort/pc/instr in,
//           core_rst/running/done/halted/timeout/cycle_count/halt_pc/
//           dbg_state out, optional hist_idx in / hist_pc out)
// -----------------------------------------------------------------------------
module core_run_ctrl #(
  parameter int W           = 32,
  parameter int RST_CYCLES  = 4,
  parameter int MAX_CYCLES  = 500,
  parameter int STALL_LIMIT = 3
`ifdef CORE_RUN_CTRL_PC_HIST_EN
  , parameter int HIST_DEPTH = 4
`endif
) (
  input logic            clk,
  input logic            rst,
  core_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int HCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SCW = $clog2(STALL_LIMIT);

  localparam logic [HCW-1:0] HOLD_INIT   = HCW'(RST_CYCLES - 1);
  localparam logic [SCW-1:0] STALL_LAST  = SCW'(STALL_LIMIT - 1);
  localparam logic [W-1:0]   BUDGET_LAST = W'(MAX_CYCLES - 1);
  localparam logic [31:0]    EBREAK      = 32'h0010_0073;

  state_t         state_q;
  logic [HCW-1:0] hold_q;
  logic [SCW-1:0] stall_q;
  logic [SCW-1:0] stall_d;
  logic           first_q;
  logic [W-1:0]   prev_pc_q;
  logic [W-1:0]   cycle_count_q;
  logic [W-1:0]   cycle_inc_d;
  logic [W-1:0]   halt_pc_q;
  logic           core_rst_q;
  logic           running_q;
  logic           done_q;
  logic           halted_q;
  logic           timeout_q;

  logic           pc_changed_d;
  logic           ebreak_d;
  logic           loop_d;
  logic           budget_d;
  logic           start_acc_d;

  // End-condition detection for the current RUN cycle. first_q makes the
  // first RUN cycle count as a pc change, so stale prev_pc_q never matters.
  always_comb begin
    pc_changed_d = first_q || (bus.pc != prev_pc_q);
    stall_d      = pc_changed_d ? '0 : stall_q + 1'b1;
    ebreak_d     = (32'(bus.instr) == EBREAK);
    loop_d       = !pc_changed_d && (stall_d == STALL_LAST);
    budget_d     = (cycle_count_q == BUDGET_LAST);
    cycle_inc_d  = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
    start_acc_d  = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      stall_q       <= '0;
      first_q       <= 1'b0;
      prev_pc_q     <= '0;
      cycle_count_q <= '0;
      halt_pc_q     <= '0;
      core_rst_q    <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      halted_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        // start wins over a simultaneous abort here; abort is meaningless
        // in these two states.
        S_IDLE, S_DONE: begin
          if (start_acc_d) begin
            state_q       <= S_HOLD;
            hold_q        <= HOLD_INIT;
            cycle_count_q <= '0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
            halt_pc_q     <= '0;
            done_q        <= 1'b0;
            running_q     <= 1'b0;
            core_rst_q    <= 1'b1;
          end
        end

        S_HOLD: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
          end else if (hold_q == '0) begin
            // core_rst drops together with the move to RUN so that the
            // first RUN cycle already sees the core out of reset.
            state_q    <= S_RUN;
            core_rst_q <= 1'b0;
            running_q  <= 1'b1;
            first_q    <= 1'b1;
            stall_q    <= '0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end

        S_RUN: begin
          // The detecting cycle is itself a RUN cycle and is counted.
          cycle_count_q <= cycle_inc_d;
          prev_pc_q     <= bus.pc;
          stall_q       <= stall_d;
          first_q       <= 1'b0;
          if (bus.abort) begin
            state_q    <= S_IDLE;
            running_q  <= 1'b0;
            core_rst_q <= 1'b1;
          end else if (ebreak_d || loop_d) begin
            state_q    <= S_DONE;
            running_q  <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b1;
            halted_q   <= 1'b1;
            halt_pc_q  <= bus.pc;
          end else if (budget_d) begin
            state_q    <= S_DONE;
            running_q  <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
            halt_pc_q  <= bus.pc;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.core_rst    = core_rst_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.halted      = halted_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.halt_pc     = halt_pc_q;
  assign bus.dbg_state   = state_q;

`ifdef CORE_RUN_CTRL_PC_HIST_EN
  localparam int HW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  logic [W-1:0]  hist_q [HIST_DEPTH];
  logic [HW-1:0] wr_ptr_q;
  logic [HW-1:0] rd_ptr_d;

  // Writes happen only in RUN, so the buffer freezes in DONE by itself.
  always_ff @(posedge clk) begin
    if (rst || start_acc_d) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else if ((state_q == S_RUN) && pc_changed_d) begin
      hist_q[wr_ptr_q] <= bus.pc;
      wr_ptr_q         <= wr_ptr_q + 1'b1;
    end
  end

  // wr_ptr_q points at the next free slot; newest entry is one behind it.
  // Power-of-two depth makes the pointer arithmetic wrap naturally.
  assign rd_ptr_d    = wr_ptr_q - 1'b1 - bus.hist_idx;
  assign bus.hist_pc = hist_q[rd_ptr_d];
`endif

endmodule
